filter_test_harness: RTL and testbench

- Synthesizable stimulus-and-capture harness for the 12-bit IIR filter bench; one module in place of separate clock/source/sink blocks.
- Emits a deterministic ramp of NB-bit samples with a valid strobe, drives constant packed filter coefficients, and captures the filter's output stream.
- Raises a sticky end-of-simulation flag once all samples are sent and a drain interval has elapsed.

---
 rtl/filter_test_harness.sv | 129 ++++++++++++
 tb/tb_filter_test_harness.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/filter_test_harness.sv
// Stimulus-and-capture harness for the 12-bit IIR filter bench: emits a ramp with a
// valid strobe, drives constant coefficients, captures the filter output, flags completion.
module filter_test_harness #(
    parameter int            NB           = 12,
    parameter int            N_SAMPLES    = 16,
    parameter logic [NB-1:0] START        = 12'h000,
    parameter logic [NB-1:0] STEP         = 12'h001,
    parameter int            GAP          = 0,
    parameter int            DRAIN_CYCLES = 10,
    parameter logic [NB-1:0] B0           = 12'h0A0,
    parameter logic [NB-1:0] B1           = 12'h140,
    parameter logic [NB-1:0] B2           = 12'h0A0,
    parameter logic [NB-1:0] A1           = 12'hE80,
    parameter logic [NB-1:0] A2           = 12'h0C0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            vOut,
    output logic [NB-1:0]   dOut,
    output logic [3*NB-1:0] b,
    output logic [2*NB-1:0] a,
    input  logic            vIn,
    input  logic [NB-1:0]   dIn,
    output logic [15:0]     rx_count,
    output logic [15:0]     checksum,
    output logic [NB-1:0]   last_sample,
    output logic            end_sim
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [GW-1:0] GAP_L   = GW'(GAP);
    localparam logic [DW-1:0] DRAIN_L = DW'(DRAIN_CYCLES);
    localparam logic [15:0]   N_L     = 16'(N_SAMPLES);

    logic            vout_q, vout_d;
    logic [NB-1:0]   dout_q, dout_d;
    logic [15:0]     sent_q, sent_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            end_q, end_d;
    logic [15:0]     rx_q, rx_d;
    logic [15:0]     sum_q, sum_d;
    logic [NB-1:0]   last_q, last_d;

    assign b = {B2, B1, B0};
    assign a = {A2, A1};

    // Source sequencing: emit, idle for GAP cycles, then drain and raise the end flag.
    always_comb begin
        vout_d  = vout_q;
        dout_d  = dout_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        drain_d = drain_q;
        end_d   = end_q;
        if (sent_q == N_L) begin
            vout_d = 1'b0;
            // The edge that drops vOut after the last sample restarts the drain count.
            if (vout_q) begin
                drain_d = {DW{1'b0}};
            end else if (!end_q) begin
                drain_d = drain_q + DW'(1);
                if (drain_d == DRAIN_L) begin
                    end_d = 1'b1;
                end else begin
                    end_d = end_q;
                end
            end else begin
                drain_d = drain_q;
            end
        end else if (gap_q == {GW{1'b0}}) begin
            vout_d = 1'b1;
            dout_d = (sent_q == 16'd0) ? START : dout_q + STEP;
            sent_d = sent_q + 16'd1;
            gap_d  = GAP_L;
        end else begin
            vout_d = 1'b0;
            gap_d  = gap_q - GW'(1);
        end
    end

    // Sink capture: count (saturating), sum and remember every valid input sample.
    always_comb begin
        rx_d   = rx_q;
        sum_d  = sum_q;
        last_d = last_q;
        if (vIn) begin
            rx_d   = (rx_q == 16'hFFFF) ? rx_q : rx_q + 16'd1;
            sum_d  = sum_q + 16'(dIn);
            last_d = dIn;
        end else begin
            last_d = last_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            vout_q  <= 1'b0;
            dout_q  <= {NB{1'b0}};
            sent_q  <= 16'd0;
            gap_q   <= {GW{1'b0}};
            drain_q <= {DW{1'b0}};
            end_q   <= 1'b0;
            rx_q    <= 16'd0;
            sum_q   <= 16'd0;
            last_q  <= {NB{1'b0}};
        end else begin
            vout_q  <= vout_d;
            dout_q  <= dout_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
            drain_q <= drain_d;
            end_q   <= end_d;
            rx_q    <= rx_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
        end
    end

    assign vOut        = vout_q;
    assign dOut        = dout_q;
    assign rx_count    = rx_q;
    assign checksum    = sum_q;
    assign last_sample = last_q;
    assign end_sim     = end_q;

endmodule

// File: tb/tb_filter_test_harness.sv
// Self-checking bench: three harness instances in loopback, compared every cycle against
// an arithmetic model of the sample schedule, plus literal spot checks.
module tb_filter_test_harness;

    typedef struct {
        logic        v;
        logic [11:0] d;
        logic        e;
        logic [15:0] rx;
        logic [15:0] cs;
        logic [11:0] last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   t_q   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    logic        v0, v1, v2, e0, e1, e2;
    logic [11:0] d0, d1, d2, l0, l1, l2;
    logic [15:0] rx0, rx1, rx2, cs0, cs1, cs2;
    logic [35:0] b0, b1, b2;
    logic [23:0] a0, a1, a2;

    always #5 clock = ~clock;

    filter_test_harness u0 (
        .clock(clock), .reset(reset), .vOut(v0), .dOut(d0), .b(b0), .a(a0),
        .vIn(v0), .dIn(d0), .rx_count(rx0), .checksum(cs0), .last_sample(l0), .end_sim(e0)
    );

    filter_test_harness #(.N_SAMPLES(4), .START(12'hFFE)) u1 (
        .clock(clock), .reset(reset), .vOut(v1), .dOut(d1), .b(b1), .a(a1),
        .vIn(v1), .dIn(d1), .rx_count(rx1), .checksum(cs1), .last_sample(l1), .end_sim(e1)
    );

    filter_test_harness #(.GAP(2)) u2 (
        .clock(clock), .reset(reset), .vOut(v2), .dOut(d2), .b(b2), .a(a2),
        .vIn(v2), .dIn(d2), .rx_count(rx2), .checksum(cs2), .last_sample(l2), .end_sim(e2)
    );

    // Number of clock edges seen with reset low since the last reset edge.
    always @(posedge clock) t_q <= reset ? 0 : t_q + 1;

    function automatic int sample(input int start, input int step, input int j);
        return (start + step * j) & 32'hFFF;
    endfunction

    // Number of valid cycles among edges 1..x.
    function automatic int nvalid(input int gap, input int n, input int x);
        int c;
        if (x < 1) return 0;
        c = (x - 1) / (gap + 1) + 1;
        return (c > n) ? n : c;
    endfunction

    function automatic exp_t model(input int start, input int step, input int gap,
                                   input int n, input int drain, input int t);
        exp_t r;
        int   idx, m, s;
        r.v = 1'b0; r.d = 12'h000; r.e = 1'b0; r.rx = 16'h0000; r.cs = 16'h0000; r.last = 12'h000;
        if (t == 0) return r;
        idx  = (t - 1) / (gap + 1);
        r.v  = ((t - 1) % (gap + 1) == 0) && (idx < n);
        r.d  = 12'(sample(start, step, (idx < n - 1) ? idx : n - 1));
        r.e  = (t >= (gap + 1) * (n - 1) + 2 + drain);
        // Loopback: the sink sees on edge t what the source showed after edge t-1.
        m = nvalid(gap, n, t - 1);
        s = 0;
        for (int j = 0; j < m; j++) s += sample(start, step, j);
        r.rx   = 16'(m);
        r.cs   = 16'(s);
        r.last = (m > 0) ? 12'(sample(start, step, m - 1)) : 12'h000;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t_q, act, req);
        end
    endtask

    task automatic cmp(input string nm, input logic v, input logic [11:0] d, input logic e,
                       input logic [15:0] rx, input logic [15:0] cs, input logic [11:0] l,
                       input exp_t x);
        check({nm, ".vOut"}, 64'(v), 64'(x.v));
        check({nm, ".dOut"}, 64'(d), 64'(x.d));
        check({nm, ".end_sim"}, 64'(e), 64'(x.e));
        check({nm, ".rx_count"}, 64'(rx), 64'(x.rx));
        check({nm, ".checksum"}, 64'(cs), 64'(x.cs));
        check({nm, ".last_sample"}, 64'(l), 64'(x.last));
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clock) begin
        cmp("u0", v0, d0, e0, rx0, cs0, l0, model(0, 1, 0, 16, 10, t_q));
        cmp("u1", v1, d1, e1, rx1, cs1, l1, model(12'hFFE, 1, 0, 4, 10, t_q));
        cmp("u2", v2, d2, e2, rx2, cs2, l2, model(0, 1, 2, 16, 10, t_q));
    end

    logic [11:0] wrap_seq [4];

    initial begin
        wrap_seq[0] = 12'hFFE; wrap_seq[1] = 12'hFFF; wrap_seq[2] = 12'h000; wrap_seq[3] = 12'h001;

        // Model self-checks against hand-computed values.
        check("model_default_t16", 64'(model(0, 1, 0, 16, 10, 16).d), 64'd15);
        check("model_default_cs", 64'(model(0, 1, 0, 16, 10, 60).cs), 64'd120);
        check("model_wrap_cs", 64'(model(12'hFFE, 1, 0, 4, 10, 60).cs), 64'h1FFE);
        check("model_gap_end", 64'(model(0, 1, 2, 16, 10, 57).e), 64'd1);

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_vOut", 64'(v0), 64'd0);
        check("rst_dOut", 64'(d0), 64'd0);
        check("rst_rx", 64'(rx0), 64'd0);
        check("rst_cs", 64'(cs0), 64'd0);
        check("rst_end", 64'(e0), 64'd0);
        check("coef_b", 64'(b0), 64'h0A0_140_0A0);
        check("coef_a", 64'(a0), 64'h0C0_E80);
        check("coef_b_u1", 64'(b1), 64'h0A0_140_0A0);
        check("coef_a_u1", 64'(a1), 64'h0C0_E80);
        check("coef_b_u2", 64'(b2), 64'h0A0_140_0A0);
        check("coef_a_u2", 64'(a2), 64'h0C0_E80);

        reset = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clock);
            if (cyc <= 4) check("wrap_dOut", 64'(d1), 64'(wrap_seq[cyc-1]));
            if (cyc == 16) check("u0_last_valid", 64'({v0, d0}), 64'h100F);
            if (cyc == 17) check("u0_vOut_low", 64'(v0), 64'd0);
            if (cyc == 26) check("u0_end_early", 64'(e0), 64'd0);
            if (cyc == 27) check("u0_end_rise", 64'(e0), 64'd1);
            if (cyc == 45) check("u2_gap_hold", 64'({v2, d2}), 64'h000E);
            if (cyc == 46) check("u2_last_valid", 64'({v2, d2}), 64'h100F);
            if (cyc == 47) check("u2_after_last", 64'(v2), 64'd0);
        end
        check("u0_rx", 64'(rx0), 64'd16);
        check("u0_cs", 64'(cs0), 64'd120);
        check("u0_last", 64'(l0), 64'd15);
        check("u1_cs", 64'(cs1), 64'h1FFE);
        check("u2_cs", 64'(cs2), 64'd120);
        check("u2_end", 64'(e2), 64'd1);

        // Mid-run reset after the sixth sample.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("pulse_pre_dOut", 64'(d0), 64'd5);
        reset = 1'b1;
        @(negedge clock);
        check("pulse_vOut", 64'(v0), 64'd0);
        check("pulse_dOut", 64'(d0), 64'd0);
        check("pulse_rx", 64'(rx0), 64'd0);
        check("pulse_cs", 64'(cs0), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("restart_dOut", 64'({v0, d0}), 64'h1000);
        repeat (59) @(negedge clock);
        check("rerun_rx", 64'(rx0), 64'd16);
        check("rerun_cs", 64'(cs0), 64'd120);
        check("rerun_end", 64'(e0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
